mdriver_arbiter: RTL and testbench
==================================

Name: mdriver_arbiter

Overview:
- Shares one mdriver master port (exec/fin four-phase handshake, 9-bit address, 32-bit data) between N_REQ requesters, e.g. CPU load/store unit, debug loader and DMA.
- Each requester sees the same four-phase exec/fin protocol as the downstream port.
- Grants one transaction at a time, round-robin.
- Includes a watchdog that aborts a downstream transaction whose fin never arrives.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- C_AXI_DATA_WIDTH, 32, data width.
- C_AXI_ADDR_WIDTH, 9, address width.
- TIMEOUT, 1024, cycles to wait for fin before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all logic on rising edge.
- nreset  in  1  synchronous active-low reset.
- req_exec  in  N_REQ  per-requester exec.
- req_we  in  N_REQ  per-requester write enable.
- req_addr  in  N_REQ*C_AXI_ADDR_WIDTH  flattened addresses; requester i at slice i.
- req_wdata  in  N_REQ*C_AXI_DATA_WIDTH  flattened write data.
- req_fin  out  N_REQ  per-requester fin.
- req_err  out  N_REQ  per-requester error; valid while req_fin is high.
- req_rdata  out  C_AXI_DATA_WIDTH  read data for the granted requester; shared bus.
- si_address  out  C_AXI_ADDR_WIDTH  downstream address.
- si_data  out  C_AXI_DATA_WIDTH  downstream write data.
- we  out  1  downstream write enable.
- exec  out  1  downstream exec.
- so_data  in  C_AXI_DATA_WIDTH  downstream read data.
- fin  in  1  downstream fin.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(N_REQ)  index of the current or last granted requester.

Behaviour:
Reset (nreset low at a clk edge, any state):
- All outputs go to 0.
- FSM goes to IDLE.
- Round-robin pointer goes to 0.
- Watchdog counter clears.
- A transaction in flight is abandoned with no completion signalled. Upstream and downstream must also be reset.

All outputs are registered. FSM states:

IDLE
- Sample req_exec. If any bit is set, select the first set bit at or above the RR pointer, wrapping modulo N_REQ.
- Latch that requester's addr, wdata and we into si_address, si_data and we.
- Set exec=1, grant_id=g, busy=1. Next state ISSUE.
- Latency: req_exec high at edge t gives exec high after edge t+1.
- Requests from other requesters in the same cycle are ignored and remain pending.

ISSUE
- Hold exec=1 and the latched fields.
- Downstream fin high at edge t: capture so_data into req_rdata, set req_fin[g]=1, req_err[g]=0, exec=0. Next state DRAIN.
- Watchdog (TIMEOUT>0): counter increments each ISSUE cycle. If it reaches TIMEOUT with fin still low: exec=0, req_rdata=0, req_fin[g]=1, req_err[g]=1. Next state DRAIN.
- If fin and timeout coincide, fin wins: normal completion.

DRAIN
- Hold req_fin[g]=1 and req_rdata.
- Exit when downstream fin==0 AND req_exec[g]==0 at the same edge: req_fin[g]=0, req_err[g]=0, RR pointer = (g+1) mod N_REQ. Next state IDLE.
- After a timeout abort, a late fin rising must also fall before exit, because the exit condition checks fin==0.

Rules:
- At most one req_fin bit is high at a time.
- req_rdata is valid only while the owner's req_fin is high. For writes it carries so_data as captured and is don't-care.
- Requester-side inputs are sampled only in IDLE. Changes to addr, wdata or we while granted have no effect.
- A requester that drops req_exec before being granted simply loses its request; there is no latching of unseen pulses.
- Minimum turnaround between back-to-back grants: one IDLE cycle.
- Fairness: with all requesters continuously requesting, grants follow 0,1,2,...,N_REQ-1,0,...
- No requester waits more than N_REQ-1 other transactions.

Test Plan:
1. Single read: requester 2 raises exec, addr=0x1A4, we=0; slave returns 0xCAFE0001 with fin after 3 cycles -> exec high 1 cycle after the request; si_address=0x1A4, we=0; req_fin[2]=1 with req_rdata=0xCAFE0001, req_err[2]=0; busy falls after req_exec[2] and fin both low.
2. Single write: requester 0, addr=0x010, wdata=0x12345678, we=1 -> si_data=0x12345678, we=1 while exec is high; req_fin[0] completes the four-phase handshake; exactly one downstream transaction is issued.
3. Contention: all 4 requesters assert simultaneously and keep re-requesting -> grant_id sequence 0,1,2,3,0,1; no two req_fin bits are ever high together.
4. RR pointer: after grant to 1, requesters 0 and 3 request together -> 3 is granted before 0.
5. Timeout: TIMEOUT=16, slave never asserts fin, requester 1 -> exec drops 16 cycles after rising; req_fin[1]=1, req_err[1]=1, req_rdata=0. A fin arriving on the same cycle as the timeout -> normal completion with req_err=0.
6. Reset mid-ISSUE: pull nreset low while exec=1 -> the next edge gives exec=0, busy=0, req_fin=0, grant_id=0; after release, requester 0 wins first.

Source files
------------

// File: rtl/mdriver_arbiter_if.sv
// Downstream mdriver bus: four-phase exec/fin handshake with separate
// write and read data paths.
//   master : drives si_address, si_data, we, exec; samples so_data, fin
//   slave  : samples si_address, si_data, we, exec; drives so_data, fin
interface mdriver_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic [AW-1:0] si_address;
  logic [DW-1:0] si_data;
  logic          we;
  logic          exec;
  logic [DW-1:0] so_data;
  logic          fin;

  modport master (output si_address, si_data, we, exec, input so_data, fin);
  modport slave  (input si_address, si_data, we, exec, output so_data, fin);
endinterface

// File: rtl/mdriver_arbiter.sv
// Round-robin arbiter sharing one mdriver master port among N_REQ
// requesters, each of which speaks the same exec/fin four-phase protocol.
// A watchdog aborts a downstream transaction whose fin never arrives.
//
// Ports:
//   clk, nreset         clock, synchronous active-low reset
//   req_exec/we/addr/wdata  per-requester request (flattened, slice i = req i)
//   req_fin/req_err     per-requester completion and error flag
//   req_rdata           read data for the owning requester (shared)
//   busy, grant_id      arbiter activity and current/last grant
//   bus                 downstream mdriver port (master side)
//
// state | meaning
// IDLE  | no transaction; pick next requester at or above rr_ptr
// ISSUE | exec high downstream, waiting for fin or watchdog expiry
// DRAIN | req_fin[g] high, waiting for downstream fin and req_exec[g] low
module mdriver_arbiter #(
  parameter int N_REQ            = 4,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 9,
  parameter int TIMEOUT          = 1024
) (
  input  logic                                  clk,
  input  logic                                  nreset,
  input  logic [N_REQ-1:0]                      req_exec,
  input  logic [N_REQ-1:0]                      req_we,
  input  logic [N_REQ*C_AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [N_REQ*C_AXI_DATA_WIDTH-1:0]     req_wdata,
  output logic [N_REQ-1:0]                      req_fin,
  output logic [N_REQ-1:0]                      req_err,
  output logic [C_AXI_DATA_WIDTH-1:0]           req_rdata,
  output logic                                  busy,
  output logic [$clog2(N_REQ)-1:0]              grant_id,
  mdriver_arbiter_if.master                     bus
);
  localparam int AW  = C_AXI_ADDR_WIDTH;
  localparam int DW  = C_AXI_DATA_WIDTH;
  localparam int GW  = $clog2(N_REQ);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Abort fires on the TIMEOUT-th ISSUE edge, so exec is high TIMEOUT cycles.
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  rr_ptr, rr_d;
  logic [WDW-1:0] wd_cnt, wd_d;
  logic [GW-1:0]  sel_idx, cand;
  logic           sel_valid;
  logic           wd_expired;

  logic [N_REQ-1:0] fin_d, err_d;
  logic [DW-1:0]    rdata_d, data_d;
  logic [AW-1:0]    addr_d;
  logic             we_d, exec_d, busy_d;
  logic [GW-1:0]    gid_d;

  // First requesting index at or above rr_ptr, wrapping. Scanning offsets
  // downward lets the smallest offset win.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = GW'((int'(rr_ptr) + i) % N_REQ);
      if (req_exec[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign wd_expired = (TIMEOUT > 0) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q        <= IDLE;
      rr_ptr         <= '0;
      wd_cnt         <= '0;
      req_fin        <= '0;
      req_err        <= '0;
      req_rdata      <= '0;
      busy           <= 1'b0;
      grant_id       <= '0;
      bus.si_address <= '0;
      bus.si_data    <= '0;
      bus.we         <= 1'b0;
      bus.exec       <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr         <= rr_d;
      wd_cnt         <= wd_d;
      req_fin        <= fin_d;
      req_err        <= err_d;
      req_rdata      <= rdata_d;
      busy           <= busy_d;
      grant_id       <= gid_d;
      bus.si_address <= addr_d;
      bus.si_data    <= data_d;
      bus.we         <= we_d;
      bus.exec       <= exec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_valid) state_d = ISSUE;
      ISSUE:   if (bus.fin || wd_expired) state_d = DRAIN;
      DRAIN:   if (!bus.fin && !req_exec[grant_id]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d    = rr_ptr;
    wd_d    = wd_cnt;
    fin_d   = req_fin;
    err_d   = req_err;
    rdata_d = req_rdata;
    gid_d   = grant_id;
    addr_d  = bus.si_address;
    data_d  = bus.si_data;
    we_d    = bus.we;
    exec_d  = bus.exec;
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (sel_valid) begin
          addr_d = req_addr[sel_idx*AW +: AW];
          data_d = req_wdata[sel_idx*DW +: DW];
          we_d   = req_we[sel_idx];
          exec_d = 1'b1;
          gid_d  = sel_idx;
        end
      end
      ISSUE: begin
        // fin has priority over a watchdog expiry on the same edge
        if (bus.fin) begin
          exec_d           = 1'b0;
          rdata_d          = bus.so_data;
          fin_d            = '0;
          fin_d[grant_id]  = 1'b1;
          err_d            = '0;
        end else if (wd_expired) begin
          exec_d           = 1'b0;
          rdata_d          = '0;
          fin_d            = '0;
          fin_d[grant_id]  = 1'b1;
          err_d            = '0;
          err_d[grant_id]  = 1'b1;
        end else begin
          wd_d = wd_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (!bus.fin && !req_exec[grant_id]) begin
          fin_d = '0;
          err_d = '0;
          rr_d  = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mdriver_arbiter.sv
module tb_mdriver_arbiter;
  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            nreset;
  logic [N-1:0]    req_exec, req_we, req_fin, req_err;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   req_rdata;
  logic            busy;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  mdriver_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mdriver_arbiter #(
    .N_REQ(N), .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .nreset(nreset),
    .req_exec(req_exec), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_fin(req_fin), .req_err(req_err), .req_rdata(req_rdata),
    .busy(busy), .grant_id(grant_id), .bus(bus)
  );

  typedef struct {
    int          id;
    logic [8:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_exec = 0;
  int   exec_len = 0;
  int   last_exec_len = 0;
  int   slv_delay = 3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slave_word(input logic [8:0] a);
    return (a == 9'h1A4) ? 32'hCAFE0001 : {16'hA5A5, 7'b0, a};
  endfunction

  function automatic exp_t mk(input int id, input logic [8:0] a, input logic we,
                              input logic [31:0] wd, input logic err);
    exp_t e;
    e.id = id; e.addr = a; e.we = we; e.wdata = wd; e.err = err;
    return e;
  endfunction

  // downstream slave: fin on the slv_delay-th edge of exec; 0 = never
  initial begin
    int cnt;
    cnt = 0;
    bus.fin = 1'b0;
    bus.so_data = '0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        cnt = 0; bus.fin = 1'b0; bus.so_data = '0;
      end else if (bus.exec && !bus.fin) begin
        cnt++;
        if (slv_delay != 0 && cnt == slv_delay) begin
          bus.so_data = slave_word(bus.si_address);
          bus.fin = 1'b1;
        end
      end else if (!bus.exec) begin
        cnt = 0;
        bus.fin = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic prev_exec;
    logic [N-1:0] prev_fin;
    exp_t e;
    prev_exec = 1'b0;
    prev_fin = '0;
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (bus.exec && !prev_exec) begin
          n_exec++;
          if (q.size() == 0) chk("exec_unexpected_qsize", q.size(), 1);
          else begin
            chk("grant_id", grant_id, q[0].id);
            chk("si_address", bus.si_address, q[0].addr);
            chk("we", bus.we, q[0].we);
            if (q[0].we) chk("si_data", bus.si_data, q[0].wdata);
          end
        end
        if (bus.exec) exec_len++;
        else if (prev_exec) begin
          last_exec_len = exec_len;
          exec_len = 0;
        end
        if (req_fin != 0) chk("fin_onehot", $onehot(req_fin), 1);
        if (req_fin != 0 && prev_fin == 0) begin
          if (q.size() == 0) chk("fin_unexpected_qsize", q.size(), 1);
          else begin
            e = q.pop_front();
            chk("fin_owner", req_fin, 32'(1) << e.id);
            chk("req_err", req_err[e.id], e.err);
            if (e.err) chk("rdata_abort", req_rdata, 0);
            else if (!e.we) chk("rdata", req_rdata, slave_word(e.addr));
          end
        end
      end else begin
        exec_len = 0;
      end
      prev_exec = bus.exec;
      prev_fin = req_fin;
    end
  end

  task automatic request(input int id, input logic [8:0] a, input logic we, input logic [31:0] wd);
    int k;
    req_addr[id*AW +: AW] = a;
    req_wdata[id*DW +: DW] = wd;
    req_we[id] = we;
    req_exec[id] = 1'b1;
    k = 0;
    while (!req_fin[id] && k < 300) begin @(negedge clk); k++; end
    chk($sformatf("fin_rise_req%0d", id), req_fin[id], 1);
    req_exec[id] = 1'b0;
    k = 0;
    while (req_fin[id] && k < 50) begin @(negedge clk); k++; end
    chk($sformatf("fin_fall_req%0d", id), req_fin[id], 0);
  endtask

  task automatic requester_loop(input int id, input int rounds);
    for (int r = 0; r < rounds; r++) request(id, 9'(64 + 8*r + id), 1'b0, 32'(id));
  endtask

  initial begin
    int k, n0;
    #200000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int k, n0;
    nreset = 1'b0;
    req_exec = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_exec", bus.exec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_fin", req_fin, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rdata", req_rdata, 0);
    nreset = 1'b1;
    @(negedge clk);

    // single read, requester 2
    slv_delay = 3;
    q.push_back(mk(2, 9'h1A4, 1'b0, 32'h0, 1'b0));
    fork
      request(2, 9'h1A4, 1'b0, 32'h0);
      begin @(negedge clk); chk("t1_exec_latency", bus.exec, 1); end
    join
    chk("t1_busy_low", busy, 0);

    // single write, requester 0
    n0 = n_exec;
    q.push_back(mk(0, 9'h010, 1'b1, 32'h12345678, 1'b0));
    request(0, 9'h010, 1'b1, 32'h12345678);
    chk("t2_one_txn", n_exec - n0, 1);

    // pointer after grant to 1: 3 beats 0
    q.push_back(mk(1, 9'h055, 1'b0, 32'h0, 1'b0));
    request(1, 9'h055, 1'b0, 32'h0);
    q.push_back(mk(3, 9'h033, 1'b0, 32'h0, 1'b0));
    q.push_back(mk(0, 9'h011, 1'b0, 32'h0, 1'b0));
    fork
      request(0, 9'h011, 1'b0, 32'h0);
      request(3, 9'h033, 1'b0, 32'h0);
    join

    // watchdog abort
    slv_delay = 0;
    q.push_back(mk(1, 9'h0F0, 1'b0, 32'h0, 1'b1));
    request(1, 9'h0F0, 1'b0, 32'h0);
    chk("t5_exec_len_abort", last_exec_len, TO);

    // fin on the expiry edge wins
    slv_delay = TO;
    q.push_back(mk(1, 9'h0F1, 1'b0, 32'h0, 1'b0));
    request(1, 9'h0F1, 1'b0, 32'h0);
    chk("t5_exec_len_coincide", last_exec_len, TO);

    // reset in ISSUE
    slv_delay = 0;
    q.push_back(mk(2, 9'h0AB, 1'b0, 32'h0, 1'b0));
    req_addr[2*AW +: AW] = 9'h0AB;
    req_we[2] = 1'b0;
    req_exec[2] = 1'b1;
    k = 0;
    while (!bus.exec && k < 20) begin @(negedge clk); k++; end
    chk("t6_exec_up", bus.exec, 1);
    @(negedge clk);
    nreset = 1'b0;
    req_exec = '0;
    @(negedge clk);
    chk("t6_exec", bus.exec, 0);
    chk("t6_busy", busy, 0);
    chk("t6_req_fin", req_fin, 0);
    chk("t6_grant", grant_id, 0);
    q.delete();
    nreset = 1'b1;
    @(negedge clk);

    // contention: grants 0,1,2,3,0,1
    slv_delay = 2;
    q.push_back(mk(0, 9'(64 + 0), 1'b0, 32'h0, 1'b0));
    q.push_back(mk(1, 9'(64 + 1), 1'b0, 32'h0, 1'b0));
    q.push_back(mk(2, 9'(64 + 2), 1'b0, 32'h0, 1'b0));
    q.push_back(mk(3, 9'(64 + 3), 1'b0, 32'h0, 1'b0));
    q.push_back(mk(0, 9'(72 + 0), 1'b0, 32'h0, 1'b0));
    q.push_back(mk(1, 9'(72 + 1), 1'b0, 32'h0, 1'b0));
    fork
      requester_loop(0, 2);
      requester_loop(1, 2);
      requester_loop(2, 1);
      requester_loop(3, 1);
    join
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
